mac_sequencer: RTL
==================

# mac_sequencer

Initiator side of the neuron multiply-accumulate interface. Holds one neuron's S weights and S inputs in local register banks, streams them as W/X pairs into the fixed-point `rmac`-style accumulator, pulses `finished`, and captures the accumulator's rectified sum. It sits between the layer controller, which loads operands and issues `start`, and the per-neuron MAC datapath.

## Interface
- `S`, 8: synapses per neuron, i.e. pairs per pass; minimum 2.
- `n`, 32: operand and result width.
- `intbits`, 12: integer bits of the Q format; passed through, not used internally.
- `fracbits`, 20: fraction bits; passed through, not used internally.
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: operand write strobe.
- `wr_sel`  in  1: 0 writes the weight bank, 1 writes the input bank.
- `wr_addr`  in  $clog2(S): operand index.
- `wr_data`  in  n: operand value.
- `start`  in  1: begin one pass; a single-cycle pulse.
- `busy`  out  1: a pass is in progress.
- `done`  out  1: one-cycle pulse; `result` is valid on this cycle.
- `result`  out  n: captured neuron output; held until the next capture or reset.
- `W`  out  n: weight presented to the MAC.
- `X`  out  n: input presented to the MAC.
- `pair_valid`  out  1: W/X are a live pair this cycle.
- `acc_clr`  out  1: one-cycle accumulator clear, active-high.
- `finished`  out  1: one-cycle end-of-pass strobe to the MAC.
- `sum_in`  in  n: MAC output sum.

## Operation
- Banks: `wbank[S]` and `xbank[S]`, each n bits wide.
  - A write takes effect on the edge where `wr_en` is high, only in IDLE.
  - Writes during any other state are dropped.
  - An out-of-range `wr_addr` (when S is not a power of 2) is dropped.
- FSM states: IDLE, CLEAR, STREAM, FINISH, CAPTURE.
  - IDLE: `start` -> CLEAR. `start` in any other state is ignored (no queuing).
  - CLEAR: `acc_clr`=1 for one cycle; index `k`<=0; -> STREAM.
  - STREAM: W=`wbank[k]`, X=`xbank[k]`, `pair_valid`=1, `k`++. Leave for FINISH when `k`==S-1 has just been issued.
  - FINISH: `finished`=1 for one cycle; -> CAPTURE.
  - CAPTURE: `result`<=`sum_in`, `done`=1; -> IDLE.
- `busy`=1 in every state except IDLE.
- Data rules:
  - Pairs are issued strictly in index order 0..S-1, one per cycle, with no bubbles.
  - W/X are registered outputs. Outside STREAM they are driven to 0.
  - `pair_valid` qualifies each pair. Repeated identical pairs are distinct samples.
  - The block does no arithmetic on data; ReLU and saturation belong to the MAC.
- Banks persist across passes. Re-running with no writes reproduces the same pair stream.

## Timing
- Cycle 0 is the edge where `start` is sampled in IDLE.
- Cycle 1: `acc_clr`.
- Cycles 2..S+1: pairs 0..S-1.
- Cycle S+2: `finished`.
- Cycle S+3: `done`, and `result` is updated at the end of that cycle.
- A new `start` is accepted from cycle S+4. Pass period is S+4 cycles.
- `sum_in` is sampled one cycle after `finished`. The MAC's output must settle within that cycle.
- A `start` coincident with `wr_en` in IDLE: the write lands and the pass starts. Pair 0 is read at cycle 2, so it sees the new value.
- Reset (asynchronous assert, synchronous deassert at the top level):
  - State returns to IDLE and `k`=0.
  - Both banks are cleared to 0 and `result`=0.
  - `busy`, `done`, `pair_valid`, `acc_clr` and `finished` are 0; W and X are 0.
  - Reset mid-pass aborts with no `done` and no `finished`.

## Structure
- Shared package (`nn_pkg`) holds:
  - the state enum;
  - the Q-format constants: `n`, `intbits`, `fracbits`, and `ONE`=1<<fracbits;
  - the `IDX_W`=$clog2(S) helper.
- One sub-module, `operand_bank`: an S×n register file with one write port, one read port, asynchronous read and reset clear. It is instantiated twice, for W and X.
- FSM and index counter live in `mac_sequencer`.

## Test plan
- **Basic pass.** S=8, all W=0x00100000 (1.0), all X=0x00080000 (0.5), `start`; the bench-model MAC accumulates on `pair_valid` -> 8 pairs on cycles 2..9, `finished` at cycle 10, `done` at cycle 11, `result`=0x00400000 (4.0).
- **Ordering and repeats.** W[k]=k<<20 and X[k]=0x00100000 -> pairs appear in order 0..7, with `pair_valid` high for exactly 8 cycles. With all W=X=0x00100000 -> 8 identical pairs each qualified, `result`=0x00800000.
- **Handshake discipline.**
  - `start` at cycle 4 of a pass -> ignored; exactly one `done`.
  - `wr_en` writing W[0]=0xFFF00000 during STREAM -> dropped; a second pass yields the same `result`.
- **Negative sum.** W=0xFFF00000 (-1.0) and X=1.0 for all k; MAC returns 0 -> `result`=0 with `done` still pulsed.
- **Reset mid-pass.** Assert `reset_n`=0 at cycle 5 ->
  - all outputs 0 asynchronously, with no `finished` or `done`;
  - after release, `busy`=0 and banks read back 0;
  - a new pass with zero banks gives `result`=0.
- **Back-to-back.** `start` at cycle S+4 after `done` -> accepted; second `done` at cycle 2S+7.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared Q-format constants, sequencer state encoding and index-width helper
// for the neuron MAC datapath.
package nn_pkg;

    localparam int unsigned n        = 32;
    localparam int unsigned intbits  = 12;
    localparam int unsigned fracbits = 20;
    localparam logic [n-1:0] ONE     = n'(1) << fracbits;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StFinish,
        StCapture
    } state_t;

    // Index width for an S-entry bank; never narrower than one bit.
    function automatic int unsigned IDX_W(input int unsigned s);
        if (s > 32'd1) return $unsigned($clog2(s));
        return 32'd1;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Pair-stream bus between the MAC sequencer (master) and the per-neuron
// multiply-accumulate datapath (slave).
interface mac_if #(
    parameter int unsigned n = 32
);

    logic [n-1:0] W;
    logic [n-1:0] X;
    logic         pair_valid;
    logic         acc_clr;
    logic         finished;
    logic [n-1:0] sum_in;

    modport master (
        output W,
        output X,
        output pair_valid,
        output acc_clr,
        output finished,
        input  sum_in
    );

    modport slave (
        input  W,
        input  X,
        input  pair_valid,
        input  acc_clr,
        input  finished,
        output sum_in
    );

endinterface

// File: rtl/mac_sequencer_operand_bank.sv
// S x n operand register file: one write port, one asynchronous read port,
// cleared on reset. Out-of-range addresses are ignored on write, read as 0.
module operand_bank #(
    parameter int unsigned S  = 8,
    parameter int unsigned n  = 32,
    parameter int unsigned AW = nn_pkg::IDX_W(S)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [n-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [n-1:0]  rdata
);

    import nn_pkg::*;

    logic [n-1:0] mem_q [S];
    logic         waddr_ok;
    logic         raddr_ok;

    assign waddr_ok = (32'(waddr) < S);
    assign raddr_ok = (32'(raddr) < S);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < S; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && waddr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = raddr_ok ? mem_q[raddr] : '0;

endmodule

// File: rtl/mac_sequencer.sv
// Initiator side of the neuron MAC interface: holds S weight/input pairs,
// streams them to the accumulator, then captures its rectified sum.
module mac_sequencer #(
    parameter int unsigned S        = 8,
    parameter int unsigned n        = nn_pkg::n,
    parameter int unsigned intbits  = nn_pkg::intbits,
    parameter int unsigned fracbits = nn_pkg::fracbits
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [nn_pkg::IDX_W(S)-1:0] wr_addr,
    input  logic [n-1:0]                wr_data,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [n-1:0]                result,
    mac_if.master                       mac
);

    import nn_pkg::*;

    localparam int unsigned IdxW = IDX_W(S);
    localparam logic [IdxW-1:0] KLast = IdxW'(S - 1);

    if (S < 2 || intbits + fracbits != n) begin : g_bad_cfg
        $error("mac_sequencer: S must be >= 2 and intbits + fracbits must equal n");
    end

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    state_t          state_q;
    logic [IdxW-1:0] k_q;
    logic            busy_q;
    logic            done_q;
    logic            pv_q;
    logic            clr_q;
    logic            fin_q;
    logic [n-1:0]    w_q;
    logic [n-1:0]    x_q;
    logic [n-1:0]    result_q;

    logic            idle_wr;
    logic            w_we;
    logic            x_we;
    logic [n-1:0]    w_rd;
    logic [n-1:0]    x_rd;

    assign idle_wr = wr_en && (state_q == StIdle);
    assign w_we    = idle_wr && !wr_sel;
    assign x_we    = idle_wr && wr_sel;

    operand_bank #(
        .S  (S),
        .n  (n),
        .AW (IdxW)
    ) u_wbank (
        .clk     (clk),
        .reset_n (rst_int_n),
        .we      (w_we),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr   (k_q),
        .rdata   (w_rd)
    );

    operand_bank #(
        .S  (S),
        .n  (n),
        .AW (IdxW)
    ) u_xbank (
        .clk     (clk),
        .reset_n (rst_int_n),
        .we      (x_we),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr   (k_q),
        .rdata   (x_rd)
    );

    // Every strobe and the W/X pair default low each cycle; only the state
    // that owns a signal raises it.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= StIdle;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pv_q     <= 1'b0;
            clr_q    <= 1'b0;
            fin_q    <= 1'b0;
            w_q      <= '0;
            x_q      <= '0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            pv_q   <= 1'b0;
            clr_q  <= 1'b0;
            fin_q  <= 1'b0;
            w_q    <= '0;
            x_q    <= '0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StClear;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    clr_q   <= 1'b1;
                    k_q     <= '0;
                    state_q <= StStream;
                end
                StStream: begin
                    w_q  <= w_rd;
                    x_q  <= x_rd;
                    pv_q <= 1'b1;
                    k_q  <= k_q + IdxW'(1);
                    if (k_q == KLast) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    fin_q   <= 1'b1;
                    k_q     <= '0;
                    state_q <= StCapture;
                end
                StCapture: begin
                    result_q <= mac.sum_in;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;
    assign mac.W          = w_q;
    assign mac.X          = x_q;
    assign mac.pair_valid = pv_q;
    assign mac.acc_clr    = clr_q;
    assign mac.finished   = fin_q;

endmodule
